// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame receiver: FSM encoding,
// error codes and the inter-byte timeout calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'h55;
  localparam int         DEF_CLK_FREQ  = 12_000_000;
  localparam int         DEF_BAUDRATE  = 9600;

  // One byte time on the line is 10 bit times (start + 8 data + stop).
  function automatic int timeout_cycles(input int clk_freq, input int baudrate,
                                        input int nbytes);
    return nbytes * 10 * (clk_freq / baudrate);
  endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte-strobe input, held-frame handshake and payload read port of the frame receiver.
// Handshake: a byte is taken only in a cycle with i_rx_done=1; o_frame_valid stays high until a cycle with i_frame_ack=1.
interface uart_frame_rx_if #(
  parameter int p_MAX_LEN = 16
);
  localparam int AW = $clog2(p_MAX_LEN);

  logic                  i_rx_done;
  logic [7:0]            i8_rx_data;
  logic                  o_frame_valid;
  logic [7:0]            o8_frame_cmd;
  logic [7:0]            o8_frame_len;
  logic                  i_frame_ack;
  logic [AW-1:0]         iN_rd_addr;
  logic [7:0]            o8_rd_data;
  logic                  o_err;
  logic [1:0]            o2_err_code;
  uart_pkg::state_t      o3_dbg_state;

  modport master (
    output i_rx_done, i8_rx_data, i_frame_ack, iN_rd_addr,
    input  o_frame_valid, o8_frame_cmd, o8_frame_len, o8_rd_data,
           o_err, o2_err_code, o3_dbg_state
  );

  modport slave (
    input  i_rx_done, i8_rx_data, i_frame_ack, iN_rd_addr,
    output o_frame_valid, o8_frame_cmd, o8_frame_len, o8_rd_data,
           o_err, o2_err_code, o3_dbg_state
  );
endinterface

// File: rtl/uart_byte_buf.sv
// Payload buffer: synchronous write, registered read. Contents survive reset;
// only the read register is cleared.
module uart_byte_buf #(
  parameter int p_DEPTH = 16,
  parameter int p_AW    = $clog2(p_DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [p_AW-1:0] iN_waddr,
  input  logic [7:0]      i8_wdata,
  input  logic [p_AW-1:0] iN_raddr,
  output logic [7:0]      o8_rdata
);

  logic [7:0] mem_q [p_DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[iN_waddr] <= i8_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= mem_q[iN_raddr];
    end
  end

  assign o8_rdata = rdata_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Assembles SYNC/CMD/LEN/payload/CHK frames from a byte strobe stream, holds a
// validated frame until acked, and pulses error codes for bad frames.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int         p_MAX_LEN       = 16,
  parameter logic [7:0] p_SYNC_BYTE     = DEF_SYNC_BYTE,
  parameter int         p_CLK_FREQ      = DEF_CLK_FREQ,
  parameter int         p_BAUDRATE      = DEF_BAUDRATE,
  parameter int         p_TIMEOUT_BYTES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  uart_frame_rx_if.slave  bus
);

  localparam int AW       = $clog2(p_MAX_LEN);
  localparam int TO_LIMIT = timeout_cycles(p_CLK_FREQ, p_BAUDRATE, p_TIMEOUT_BYTES);
  localparam int TW       = $clog2(TO_LIMIT + 1);

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      chk_q, chk_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            buf_we;
  logic            to_active;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 8'h00;
      len_q      <= 8'h00;
      chk_q      <= 8'h00;
      idx_q      <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      idx_q      <= idx_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign to_active = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                     (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    chk_d      = chk_q;
    idx_d      = idx_q;
    to_cnt_d   = to_cnt_q;
    err_d      = 1'b0;
    err_code_d = ERR_LEN;
    buf_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_rx_done && bus.i8_rx_data == p_SYNC_BYTE) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (bus.i_rx_done) begin
          cmd_d   = bus.i8_rx_data;
          chk_d   = bus.i8_rx_data;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (bus.i_rx_done) begin
          if (bus.i8_rx_data > 8'(p_MAX_LEN)) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d   = bus.i8_rx_data;
            chk_d   = chk_q ^ bus.i8_rx_data;
            idx_d   = '0;
            state_d = (bus.i8_rx_data == 8'h00) ? ST_CHK : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (bus.i_rx_done) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ bus.i8_rx_data;
          if (8'(idx_q) == len_q - 8'd1) begin
            state_d = ST_CHK;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      ST_CHK: begin
        if (bus.i_rx_done) begin
          if (bus.i8_rx_data == chk_q) begin
            state_d = ST_HOLD;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // Ack has priority: a byte arriving with the ack is dropped silently.
        if (bus.i_frame_ack) begin
          state_d = ST_IDLE;
        end else if (bus.i_rx_done) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout only fires in cycles without a byte, so it never collides with another error.
    if (!to_active) begin
      to_cnt_d = '0;
    end else if (bus.i_rx_done) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TO_LIMIT - 1)) begin
      to_cnt_d   = '0;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_IDLE;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_comb begin
    bus.o_frame_valid = (state_q == ST_HOLD);
    bus.o8_frame_cmd  = cmd_q;
    bus.o8_frame_len  = len_q;
    bus.o_err         = err_q;
    bus.o2_err_code   = err_code_q;
    bus.o3_dbg_state  = state_q;
  end

  uart_byte_buf #(
    .p_DEPTH (p_MAX_LEN),
    .p_AW    (AW)
  ) u_buf (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (buf_we),
    .iN_waddr (idx_q),
    .i8_wdata (bus.i8_rx_data),
    .iN_raddr (bus.iN_rd_addr),
    .o8_rdata (bus.o8_rd_data)
  );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed frames plus random frame traffic, checked
// every cycle against a frame-level reference model.
module tb_uart_frame_rx;
  import uart_pkg::*;

  localparam int         MAXL  = 16;
  localparam int         CLKF  = 96_000;
  localparam int         BAUD  = 9600;
  localparam int         TOB   = 4;
  localparam int         LIMIT = TOB * 10 * (CLKF / BAUD);
  localparam logic [7:0] SYNC  = 8'h55;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_frame_rx_if #(.p_MAX_LEN(MAXL)) bus ();

  uart_frame_rx #(
    .p_MAX_LEN       (MAXL),
    .p_SYNC_BYTE     (SYNC),
    .p_CLK_FREQ      (CLKF),
    .p_BAUDRATE      (BAUD),
    .p_TIMEOUT_BYTES (TOB)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model: bytes of the frame in progress, and the held frame
  bit         in_frame = 1'b0;
  bit         holding  = 1'b0;
  int         gap      = 0;
  logic [7:0] pend[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_cmd, m_len;
  bit         exp_err;
  logic [1:0] exp_code;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_cycle(input bit done, input logic [7:0] b, input bit ack);
    logic [7:0] x;
    exp_err  = 1'b0;
    exp_code = 2'd0;
    if (holding) begin
      if (ack) holding = 1'b0;
      else if (done) begin exp_err = 1'b1; exp_code = ERR_OVERRUN; end
    end else if (!in_frame) begin
      if (done && b == SYNC) begin in_frame = 1'b1; pend.delete(); gap = 0; end
    end else if (done) begin
      gap = 0;
      pend.push_back(b);
      if (pend.size() == 2 && int'(pend[1]) > MAXL) begin
        exp_err = 1'b1; exp_code = ERR_LEN; in_frame = 1'b0;
      end else if (pend.size() >= 2 && pend.size() == int'(pend[1]) + 3) begin
        x = 8'h00;
        for (int i = 0; i < pend.size() - 1; i++) x ^= pend[i];
        in_frame = 1'b0;
        if (x == b) begin
          holding = 1'b1;
          m_cmd   = pend[0];
          m_len   = pend[1];
          exp_q.delete();
          for (int i = 2; i < pend.size() - 1; i++) exp_q.push_back(pend[i]);
        end else begin
          exp_err = 1'b1; exp_code = ERR_CHK;
        end
      end
    end else begin
      gap++;
      if (gap == LIMIT) begin exp_err = 1'b1; exp_code = ERR_TIMEOUT; in_frame = 1'b0; end
    end
  endtask

  // one clock: drive inputs, let the edge happen, compare against the model
  task automatic step(input bit done, input logic [7:0] b, input bit ack, input int addr);
    bus.i_rx_done   = done;
    bus.i8_rx_data  = b;
    bus.i_frame_ack = ack;
    bus.iN_rd_addr  = 4'(addr);
    @(posedge clk);
    #1;
    model_cycle(done, b, ack);
    check_eq("err", 32'(bus.o_err), 32'(exp_err));
    if (exp_err) check_eq("err_code", 32'(bus.o2_err_code), 32'(exp_code));
    check_eq("valid", 32'(bus.o_frame_valid), 32'(holding));
    if (holding) begin
      check_eq("cmd", 32'(bus.o8_frame_cmd), 32'(m_cmd));
      check_eq("len", 32'(bus.o8_frame_len), 32'(m_len));
      if (addr < exp_q.size()) check_eq("rd_data", 32'(bus.o8_rd_data), 32'(exp_q[addr]));
    end
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, $urandom_range(0, MAXL - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, $urandom_range(0, MAXL - 1));
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input int max_gap);
    for (int i = 0; i < q.size(); i++) begin
      send(q[i]);
      idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_rx_done = 1'b0; bus.i8_rx_data = 8'h00; bus.i_frame_ack = 1'b0; bus.iN_rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(bus.o_frame_valid), 32'd0);
    check_eq("rst_err", 32'(bus.o_err), 32'd0);
    check_eq("rst_code", 32'(bus.o2_err_code), 32'd0);
    check_eq("rst_cmd", 32'(bus.o8_frame_cmd), 32'd0);
    check_eq("rst_len", 32'(bus.o8_frame_len), 32'd0);
    check_eq("rst_rd_data", 32'(bus.o8_rd_data), 32'd0);
    check_eq("rst_state", 32'(bus.o3_dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    in_frame = 1'b0; holding = 1'b0; gap = 0; pend.delete();
  endtask

  // read every payload address, optionally provoke an overrun, then ack
  task automatic drain_frame();
    for (int a = 0; a < MAXL; a++) step(1'b0, 8'h00, 1'b0, a);
    if ($urandom_range(0, 1) == 1) send(8'($urandom));
    step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 0);
  endtask

  task automatic flush();
    if (holding) drain_frame();
    if (in_frame) idle(LIMIT + 1);
  endtask

  function automatic logic [7:0] nonsync();
    logic [7:0] v;
    v = 8'($urandom);
    return (v == SYNC) ? 8'h00 : v;
  endfunction

  initial begin
    logic [7:0] q[$];
    logic [7:0] x;
    int         kind, len;

    do_reset();

    // frame accepted, payload readback, ack
    send_bytes('{8'h55, 8'h10, 8'h02, 8'hAB, 8'hCD, 8'h74}, 0);
    step(1'b0, 8'h00, 1'b0, 0);
    step(1'b0, 8'h00, 1'b0, 1);
    step(1'b0, 8'h00, 1'b1, 0);
    idle(1);

    // checksum mismatch, then a zero-length frame
    send_bytes('{8'h55, 8'h10, 8'h02, 8'hAB, 8'hCD, 8'h00}, 1);
    send_bytes('{8'h55, 8'h20, 8'h00, 8'h20}, 0);
    step(1'b0, 8'h00, 1'b1, 0);

    // LEN too large; following bytes ignored
    send_bytes('{8'h55, 8'h10, 8'h11, 8'h01, 8'h02, 8'h03}, 0);

    // timeout after CMD, then a good frame
    send_bytes('{8'h55, 8'h10}, 0);
    idle(LIMIT + 5);
    send_bytes('{8'h55, 8'h10, 8'h02, 8'hAB, 8'hCD, 8'h74}, 0);

    // overrun while holding, then ack coincident with a byte
    send(8'h55);
    step(1'b0, 8'h00, 1'b0, 0);
    step(1'b0, 8'h00, 1'b0, 1);
    step(1'b1, 8'h55, 1'b1, 0);
    check_eq("state_after_ack", 32'(bus.o3_dbg_state), 32'(ST_IDLE));
    idle(2);

    // garbage before sync; reset mid-frame
    send_bytes('{8'h00, 8'hFF, 8'h55, 8'h20, 8'h00, 8'h20}, 0);
    step(1'b0, 8'h00, 1'b1, 0);
    send_bytes('{8'h55, 8'h20}, 0);
    do_reset();
    idle(3);
    send_bytes('{8'h55, 8'h20, 8'h00, 8'h20}, 0);
    flush();

    // random traffic
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 5);
      q.delete();
      len = $urandom_range(0, MAXL);
      q.push_back(SYNC);
      q.push_back(8'($urandom));
      x = q[1];
      case (kind)
        3: begin
          q.push_back(8'($urandom_range(MAXL + 1, 255)));
        end
        4: begin
          q.delete();
          for (int i = 0; i < 5; i++) q.push_back(nonsync());
        end
        default: begin
          q.push_back(8'(len));
          x ^= 8'(len);
          for (int i = 0; i < len; i++) begin
            q.push_back(8'($urandom));
            x ^= q[q.size() - 1];
          end
          if (kind == 2) x ^= 8'($urandom_range(1, 255));
          q.push_back(x);
          if (kind == 5) q = q[0:$urandom_range(1, q.size() - 2)];
        end
      endcase
      send_bytes(q, 2);
      flush();
    end

    bus.i_rx_done = 1'b0;
    bus.i_frame_ack = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
